// File: rtl/mgmt_hub_pkg.sv
// Shared definitions for the management-bus hub: FSM states, error codes,
// error read data and the slave index map.
package mgmt_hub_pkg;

    // Hub sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } hub_state_t;

    // Values reported on err_code
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_PROTOCOL = 2'd3;

    // Read data handed back to the master on an error completion
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Slave index map (value of the address select field)
    localparam int SLV_SYSREG   = 0;
    localparam int SLV_MC       = 1;
    localparam int SLV_PIC      = 2;
    localparam int SLV_NET      = 3;
    localparam int SLV_DBG      = 4;
    localparam int NSLV_DEFAULT = 5;

    // When several error sources fire in one cycle, the access-level causes
    // (unmapped, then timeout) take precedence over a stray slave pulse.
    function automatic logic [1:0] err_pick(input logic unmapped,
                                            input logic timeout,
                                            input logic protocol);
        if (unmapped) return ERR_UNMAPPED;
        if (timeout)  return ERR_TIMEOUT;
        if (protocol) return ERR_PROTOCOL;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/mgmt_hub_tmo.sv
// Timeout counter for the hub: cleared while no slave response is awaited,
// counts every cycle it is enabled, and flags expiry on the cycle whose
// closing edge would bring the count to all-ones, so a slave gets exactly
// 2^TMO_W-1 cycles to answer.
module mgmt_hub_tmo
    import mgmt_hub_pkg::*;
#(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TMO_W-1:0] ALL_ONES = '1;
    localparam logic [TMO_W-1:0] FIRE_AT  = ALL_ONES - TMO_W'(1);

    logic [TMO_W-1:0] cnt_reg;

    // Clear has priority over counting; the count saturates rather than wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != ALL_ONES)) begin
            cnt_reg <= cnt_reg + TMO_W'(1);
        end
    end

    assign expire = en && (cnt_reg == FIRE_AT);

endmodule

// File: rtl/mgmt_hub.sv
// mgmt_hub: sequences single outstanding accesses from the core's mgmt bus
// to one of NSLV point-to-point slaves, registers the slave's ack/read data
// back to the master, and turns unmapped addresses, hung slaves and stray
// slave pulses into a defined error completion plus sticky error status.
module mgmt_hub
    import mgmt_hub_pkg::*;
#(
    parameter int          NSLV     = NSLV_DEFAULT,
    parameter int          SEL_LSB  = 12,
    parameter int          SEL_W    = 4,
    parameter int          TMO_W    = 8,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_req,
    input  logic [31:0]         m_adr,
    input  logic                m_rwn,
    input  logic [1:0]          m_wen,
    input  logic [31:0]         m_txd,
    output logic                m_ack,
    output logic                m_rxe,
    output logic [31:0]         m_rxd,
    output logic [NSLV-1:0]     s_req,
    output logic [31:0]         s_adr,
    output logic                s_rwn,
    output logic [1:0]          s_wen,
    output logic [31:0]         s_txd,
    input  logic [NSLV-1:0]     s_ack,
    input  logic [NSLV-1:0]     s_rxe,
    input  logic [32*NSLV-1:0]  s_rxd,
    input  logic                err_clr,
    output logic                err_flag,
    output logic [1:0]          err_code,
    output logic [31:0]         err_adr
);

    hub_state_t       state_reg;
    logic [SEL_W-1:0] sel_reg;          // slave index of the access in flight
    logic             err_ack_pend_reg; // ERR still owes the master its m_ack

    logic [SEL_W-1:0] m_sel;
    logic [NSLV-1:0]  m_sel_onehot;
    logic [NSLV-1:0]  sel_onehot;
    logic [31:0]      rxd_lane [NSLV];
    logic [31:0]      sel_rxd;

    logic             mapped;
    logic             accept;
    logic             in_req;
    logic             in_resp;
    logic             ack_hit;
    logic             rxe_hit;
    logic [NSLV-1:0]  ack_ok;
    logic [NSLV-1:0]  rxe_ok;
    logic             proto_err;
    logic             timeout_err;
    logic             unmapped_err;
    logic             new_err;
    logic [1:0]       new_code;
    logic [31:0]      new_adr;

    logic             tmo_clr;
    logic             tmo_en;
    logic             tmo_expire;

    assign m_sel = m_adr[SEL_LSB +: SEL_W];

    // Per-slave decode of the incoming and the latched select field, plus
    // the read-data lanes split out of the flat bus
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_lane
            assign m_sel_onehot[gi] = (m_sel == SEL_W'(gi));
            assign sel_onehot[gi]   = (sel_reg == SEL_W'(gi));
            assign rxd_lane[gi]     = s_rxd[32*gi +: 32];
        end
    endgenerate

    // An address is mapped exactly when its select field names a real slave
    assign mapped = |m_sel_onehot;

    // Read-data mux onto the selected slave's lane
    always_comb begin
        sel_rxd = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rxd = sel_rxd | (rxd_lane[i] & {32{sel_onehot[i]}});
        end
    end

    // Accept only while m_ack is low so the still-held request of the access
    // just completed is not taken a second time.
    assign accept  = (state_reg == ST_IDLE) && m_req && !m_ack;
    assign in_req  = (state_reg == ST_REQ);
    assign in_resp = (state_reg == ST_RESP);

    assign ack_hit = in_req  && |(s_ack & sel_onehot);
    assign rxe_hit = in_resp && |(s_rxe & sel_onehot);

    // The only pulse expected is from the selected slave in the matching
    // phase; anything else (other slaves, wrong phase, after an abort) is
    // a protocol error and otherwise ignored.
    assign ack_ok    = in_req  ? sel_onehot : '0;
    assign rxe_ok    = in_resp ? sel_onehot : '0;
    assign proto_err = (|(s_ack & ~ack_ok)) || (|(s_rxe & ~rxe_ok));

    // A response arriving on the expiry cycle still wins over the timeout
    assign timeout_err  = tmo_expire && ((in_req && !ack_hit) || (in_resp && !rxe_hit));
    assign unmapped_err = accept && !mapped;

    assign new_err  = unmapped_err || timeout_err || proto_err;
    assign new_code = err_pick(unmapped_err, timeout_err, proto_err);
    assign new_adr  = unmapped_err ? m_adr : s_adr;

    // The counter restarts on every entry to REQ or RESP: it sits cleared
    // outside those states and is cleared again on the REQ->RESP hand-over.
    assign tmo_en  = in_req || in_resp;
    assign tmo_clr = !tmo_en || ack_hit;

    mgmt_hub_tmo #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    // Transaction sequencer with registered master/slave side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            sel_reg          <= '0;
            err_ack_pend_reg <= 1'b0;
            m_ack            <= 1'b0;
            m_rxe            <= 1'b0;
            m_rxd            <= '0;
            s_req            <= '0;
            s_adr            <= '0;
            s_rwn            <= 1'b0;
            s_wen            <= '0;
            s_txd            <= '0;
        end else begin
            m_ack <= 1'b0;
            m_rxe <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        s_adr   <= m_adr;
                        s_rwn   <= m_rwn;
                        s_wen   <= m_wen;
                        s_txd   <= m_txd;
                        sel_reg <= m_sel;
                        if (mapped) begin
                            s_req     <= m_sel_onehot;
                            state_reg <= ST_REQ;
                        end else begin
                            err_ack_pend_reg <= 1'b1;
                            state_reg        <= ST_ERR;
                        end
                    end
                end
                ST_REQ: begin
                    if (ack_hit) begin
                        s_req     <= '0;
                        m_ack     <= 1'b1;
                        state_reg <= s_rwn ? ST_RESP : ST_IDLE;
                    end else if (tmo_expire) begin
                        s_req            <= '0;
                        err_ack_pend_reg <= 1'b1;
                        state_reg        <= ST_ERR;
                    end
                end
                ST_RESP: begin
                    if (rxe_hit) begin
                        m_rxe     <= 1'b1;
                        m_rxd     <= sel_rxd;
                        state_reg <= ST_IDLE;
                    end else if (tmo_expire) begin
                        // m_ack was already given; only the data phase is owed
                        err_ack_pend_reg <= 1'b0;
                        state_reg        <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (err_ack_pend_reg) begin
                        m_ack            <= 1'b1;
                        err_ack_pend_reg <= 1'b0;
                        if (!s_rwn) begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        m_rxe     <= 1'b1;
                        m_rxd     <= ERR_DATA;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sticky error log: keeps the first error; a clear coinciding with a new
    // error records the new one instead of clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_code <= ERR_NONE;
            err_adr  <= '0;
        end else if (new_err && (!err_flag || err_clr)) begin
            err_flag <= 1'b1;
            err_code <= new_code;
            err_adr  <= new_adr;
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_code <= ERR_NONE;
        end
    end

endmodule
